// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: fetch read port, valid/ready loader write port,
// and a one-word-per-cycle clear sweep after reset that is reported on busy.
module instr_mem_loadable #(
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       ADDR_W  = 16,
    parameter int unsigned       DEPTH   = 1000,
    parameter logic [DATA_W-1:0] FILL    = '0,
    parameter bit                REG_OUT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instruction,
    output logic              busy,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e            state_q;
    logic [PTR_W-1:0]  clr_ptr_q;
    logic              busy_q;
    logic              ld_err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ld_accept_c;
    logic              ld_in_range_c;
    logic              fetch_in_range_c;
    logic [PTR_W-1:0]  ld_idx_c;
    logic [PTR_W-1:0]  fetch_idx_c;
    logic [DATA_W-1:0] rd_word_c;

    // Range checks are full-width unsigned so out-of-range addresses never alias into the array.
    assign ld_in_range_c    = 64'(ld_addr) < 64'(DEPTH);
    assign fetch_in_range_c = 64'(address) < 64'(DEPTH);
    assign ld_idx_c         = PTR_W'(ld_addr);
    assign fetch_idx_c      = PTR_W'(address);
    assign ld_accept_c      = ld_valid && !busy_q;

    assign busy     = busy_q;
    assign ld_ready = !busy_q;
    assign ld_err   = ld_err_q;

    // Clear-sweep FSM and loader error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
            ld_err_q  <= 1'b0;
        end else begin
            ld_err_q <= ld_accept_c && !ld_in_range_c;
            case (state_q)
                CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + PTR_W'(1);
                    if (clr_ptr_q == PTR_W'(DEPTH - 1)) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        clr_ptr_q <= '0;
                    end
                end
                IDLE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_ptr_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Array writes: the sweep owns the array while busy, the loader afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[clr_ptr_q] <= '0;
            end else if (ld_accept_c && ld_in_range_c) begin
                mem[ld_idx_c] <= ld_data;
            end
        end
    end

    assign rd_word_c = (busy_q || !fetch_in_range_c) ? FILL : mem[fetch_idx_c];

    // Registered fetch samples the pre-write array contents (read-before-write).
    if (REG_OUT) begin : g_reg_out
        logic [DATA_W-1:0] instr_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                instr_q <= FILL;
            end else begin
                instr_q <= rd_word_c;
            end
        end
        assign instruction = instr_q;
    end else begin : g_comb_out
        assign instruction = rd_word_c;
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: one combinational-read and one
// registered-read instance share stimulus; DEPTH=8, FILL=0.
module tb_instr_mem_loadable;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] address;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic [DW-1:0] instr0, instr1;
    logic          busy0, busy1, rdy0, rdy1, err0, err1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_mem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FILL(16'h0), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst(rst), .address(address), .instruction(instr0), .busy(busy0),
        .ld_valid(ld_valid), .ld_ready(rdy0), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(err0)
    );

    instr_mem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FILL(16'h0), .REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst(rst), .address(address), .instruction(instr1), .busy(busy1),
        .ld_valid(ld_valid), .ld_ready(rdy1), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(err1)
    );

    // e0: comb read after the edge; e1: registered read sampled at the edge
    // (equals the comb read just before the edge); err: ld_err after the edge.
    typedef struct {
        logic          v;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic [AW-1:0] addr;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic          err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called with rst already low before the first sweep edge.
    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk({tag, "_busy0"}, 32'(busy0), 32'(i < 8));
            chk({tag, "_busy1"}, 32'(busy1), 32'(i < 8));
            chk({tag, "_rdy0"},  32'(rdy0),  32'(i == 8));
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            address = AW'(a);
            #1;
            chk({tag, "_rd0"}, 32'(instr0), 32'h0);
            step();
            chk({tag, "_rd1"}, 32'(instr1), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 16'h0003, 16'h8808, 16'h0003, 16'h8808, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h0007, 16'h05F4, 16'h0007, 16'h05F4, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 16'h0003, 16'h8808, 16'h8808, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 16'h0007, 16'h05F4, 16'h05F4, 1'b0};
        vecs[4]  = '{1'b1, 16'h0008, 16'hFFFF, 16'h0008, 16'h0000, 16'h0000, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 16'hFFFF, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 16'h0009, 16'h2222, 16'h0007, 16'h05F4, 16'h05F4, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 16'h0002, 16'h0001, 16'h0005, 16'h0000, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, 16'h0002, 16'h1234, 16'h0002, 16'h1234, 16'h0001, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 16'h0000, 16'h0002, 16'h1234, 16'h1234, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 16'h0000, 16'h000A, 16'h0000, 16'h0000, 1'b0};
        vecs[13] = '{1'b1, 16'h0000, 16'hABCD, 16'h0000, 16'hABCD, 16'h0000, 1'b0};

        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        address  = '0;

        // Reset values
        step();
        chk("rst_busy0", 32'(busy0), 32'h1);
        chk("rst_busy1", 32'(busy1), 32'h1);
        chk("rst_rdy0",  32'(rdy0),  32'h0);
        chk("rst_rdy1",  32'(rdy1),  32'h0);
        chk("rst_err0",  32'(err0),  32'h0);
        chk("rst_err1",  32'(err1),  32'h0);
        chk("rst_instr0", 32'(instr0), 32'h0);
        chk("rst_instr1", 32'(instr1), 32'h0);

        // Clear sweep length and post-clear contents
        @(negedge clk);
        rst = 1'b0;
        sweep_check("sweep1");
        read_all_zero("clr1");

        // Loader / fetch vector table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            ld_valid = vecs[i].v;
            ld_addr  = vecs[i].la;
            ld_data  = vecs[i].ld;
            address  = vecs[i].addr;
            #1;
            chk($sformatf("v%0d_pre0", i), 32'(instr0), 32'(vecs[i].e1));
            step();
            chk($sformatf("v%0d_instr0", i), 32'(instr0), 32'(vecs[i].e0));
            chk($sformatf("v%0d_instr1", i), 32'(instr1), 32'(vecs[i].e1));
            chk($sformatf("v%0d_err0", i),   32'(err0),   32'(vecs[i].err));
            chk($sformatf("v%0d_err1", i),   32'(err1),   32'(vecs[i].err));
            chk($sformatf("v%0d_rdy0", i),   32'(rdy0),   32'h1);
        end
        @(negedge clk);
        ld_valid = 1'b0;

        // Reset re-asserted three cycles into a sweep restarts it from zero
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rst2_busy0", 32'(busy0), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        sweep_check("sweep2");
        read_all_zero("clr2");

        // Loader request held through the sweep lands exactly once
        @(negedge clk);
        rst      = 1'b1;
        ld_valid = 1'b1;
        ld_addr  = 16'h0004;
        ld_data  = 16'hBEEF;
        address  = 16'h0004;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sweep_check("sweep3");
        chk("hold_nowrite0", 32'(instr0), 32'h0);
        chk("hold_noerr0",   32'(err0),   32'h0);
        step();
        chk("hold_land0",  32'(instr0), 32'hBEEF);
        chk("hold_land1",  32'(instr1), 32'h0);
        chk("hold_err0",   32'(err0),   32'h0);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = 16'hCAFE;
        step();
        chk("hold_once0", 32'(instr0), 32'hBEEF);
        chk("hold_once1", 32'(instr1), 32'hBEEF);
        step();
        chk("hold_keep0", 32'(instr0), 32'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
